snn_timestep_scheduler: RTL

- Sequences one SNN inference across NUM_STEPS timesteps.
- Starts on the preprocessing-done pulse and clears neuron state. For each timestep it pulses spike generation to start, then waits for both spike generation and the neuron layer to finish.
- Sits between the preprocessing stage and the spike-generation / neuron-core datapath. It is the only source of step_start and neuron_clear.

---
 rtl/snn_timestep_scheduler.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/snn_timestep_scheduler.sv
// SNN timestep scheduler: clear, per-step start, completion join, done pulse.
// Optional per-step watchdog enabled by SNN_STEP_TIMEOUT_EN.
module snn_timestep_scheduler #(
  parameter int NUM_STEPS      = 20,
  parameter int STEP_W         = 5,
  parameter int CLEAR_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pre_processing_done,
  input  logic              abort,
  output logic              step_start,
  input  logic              current_step_finished,
  input  logic              layer_done,
  output logic              neuron_clear,
  output logic [STEP_W-1:0] timestep,
  output logic              busy,
  output logic              inference_done,
  output logic              overrun,
  output logic              timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_START,
    S_WAIT,
    S_DONE
  } state_e;

  localparam int CLR_W =
    (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST =
    CLR_W'(CLEAR_CYCLES - 1);
  localparam logic [STEP_W-1:0] STEP_LAST =
    STEP_W'(NUM_STEPS - 1);

  if (NUM_STEPS < 1 || NUM_STEPS > (1 << STEP_W) ||
      CLEAR_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("snn_timestep_scheduler: illegal parameters");
  end

  state_e            state_q;
  logic [CLR_W-1:0]  clr_q;
  logic [STEP_W-1:0] ts_q;
  logic              gen_f_q;
  logic              lay_f_q;
  logic              ss_q;
  logic              nc_q;
  logic              busy_q;
  logic              done_q;
  logic              ovr_q;

  logic gen_d;
  logic lay_d;
  logic both_d;
  logic to_hit;
  logic kill;

  // Completion joins the sticky flag with the pulse arriving this cycle.
  assign gen_d  = gen_f_q | current_step_finished;
  assign lay_d  = lay_f_q | layer_done;
  assign both_d = gen_d & lay_d;
  assign kill   = (abort | to_hit) & (state_q != S_IDLE);

`ifdef SNN_STEP_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            to_err_q;

  assign to_hit = (state_q == S_WAIT) & ~both_d &
                  (to_cnt_q == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
      to_err_q <= 1'b0;
    end else begin
      if (state_q == S_START)
        to_cnt_q <= '0;
      else if (state_q == S_WAIT)
        to_cnt_q <= to_cnt_q + TO_W'(1);
      if (to_hit)
        to_err_q <= 1'b1;
      else if (state_q == S_IDLE && pre_processing_done && !abort)
        to_err_q <= 1'b0;
    end
  end

  assign timeout_err = to_err_q;
`else
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      clr_q   <= '0;
      ts_q    <= '0;
      gen_f_q <= 1'b0;
      lay_f_q <= 1'b0;
      ss_q    <= 1'b0;
      nc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ss_q   <= 1'b0;
      done_q <= 1'b0;
      if (pre_processing_done && state_q != S_IDLE)
        ovr_q <= 1'b1;
      if (kill) begin
        state_q <= S_IDLE;
        clr_q   <= '0;
        ts_q    <= '0;
        gen_f_q <= 1'b0;
        lay_f_q <= 1'b0;
        nc_q    <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            ts_q <= '0;
            if (pre_processing_done && !abort) begin
              state_q <= S_CLEAR;
              clr_q   <= '0;
              nc_q    <= 1'b1;
              busy_q  <= 1'b1;
              ovr_q   <= 1'b0;
            end
          end
          S_CLEAR: begin
            if (clr_q == CLR_LAST) begin
              state_q <= S_START;
              nc_q    <= 1'b0;
              ss_q    <= 1'b1;
            end else begin
              clr_q <= clr_q + CLR_W'(1);
            end
          end
          S_START: begin
            state_q <= S_WAIT;
            gen_f_q <= 1'b0;
            lay_f_q <= 1'b0;
          end
          S_WAIT: begin
            gen_f_q <= gen_d;
            lay_f_q <= lay_d;
            if (both_d) begin
              if (ts_q == STEP_LAST) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_START;
                ts_q    <= ts_q + STEP_W'(1);
                ss_q    <= 1'b1;
              end
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            ts_q    <= '0;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign step_start     = ss_q;
  assign neuron_clear   = nc_q;
  assign timestep       = ts_q;
  assign busy           = busy_q;
  assign inference_done = done_q;
  assign overrun        = ovr_q;

endmodule
